// File: rtl/uart_pkg.sv
// Shared UART definitions for the tx and rx engines: FSM state encodings,
// oversample default, rx_conf field layout and size-decode helpers.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DATA_W         = 8;
  localparam int unsigned BIT_IDX_W      = 3;
  localparam int unsigned CONF_W         = 5;

  // Field positions inside rx_conf / tx_conf.
  localparam int unsigned CONF_PARITY_EN = 0;
  localparam int unsigned CONF_STOP_LSB  = 1;
  localparam int unsigned CONF_STOP_MSB  = 2;
  localparam int unsigned CONF_DSIZE_LSB = 3;
  localparam int unsigned CONF_DSIZE_MSB = 4;

  // Size decode: data bits = DATA_BITS_MIN + dsize; stop bits = 1 when stop == 0, else 2.
  localparam int unsigned DATA_BITS_MIN  = 5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START_CHK = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_DONE      = 3'd5
  } uart_state_e;

  // Packed view of the conf word; member order matches the field positions above.
  typedef struct packed {
    logic [CONF_DSIZE_MSB-CONF_DSIZE_LSB:0] dsize;
    logic [CONF_STOP_MSB-CONF_STOP_LSB:0]   stop;
    logic                                   parity_en;
  } uart_conf_t;

  // Index of the last data bit of a frame.
  function automatic logic [BIT_IDX_W-1:0] last_data_idx(input logic [1:0] dsize);
    return BIT_IDX_W'(DATA_BITS_MIN - 1) + BIT_IDX_W'(dsize);
  endfunction

  // True when the frame carries two stop bits.
  function automatic logic two_stop_bits(input logic [1:0] stop);
    return stop != 2'd0;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Synchroniser for the asynchronous serial line, resetting to the idle (high)
// level, plus a falling-edge detect on the synchronised value.
//   clk_i, rst_i : clock, asynchronous active-low reset
//   rx_line      : raw serial input
//   rx_s         : synchronised line (registered)
//   rx_fall_c    : combinational 1->0 detect on rx_s
module uart_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_line,
  output logic rx_s,
  output logic rx_fall_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_prev_q;

  // Shift chain; reset to 1 so a reset release never looks like a start bit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_line};
      rx_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign rx_fall_c = rx_prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_module.sv
// UART receive engine: 16x oversampled deserialiser for 5-8 data bits, LSB
// first, optional even parity, 1 or 2 stop bits; valid/ready output port.
//   clk_i, rst_i     : clock, asynchronous active-low reset
//   baud_en_i        : oversample tick (OVERSAMPLE per bit)
//   rx_en_i          : receiver enable
//   rx_conf_i        : {data_size[1:0], stop_size[1:0], parity_en}
//   uart_rx_i        : asynchronous serial line, idle high
//   rx_ready_i       : consumer accepts the presented byte
//   rx_data_o        : received data, right-aligned
//   rx_valid_o       : data and flags valid, held until accepted
//   rx_parity_err_o  : parity mismatch of presented frame
//   rx_frame_err_o   : low stop bit in presented frame
//   rx_overrun_o     : sticky, frame dropped while output was still full
//   rx_busy_o        : frame in progress
module uart_rx_module
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                baud_en_i,
  input  logic                rx_en_i,
  input  logic [CONF_W-1:0]   rx_conf_i,
  input  logic                uart_rx_i,
  input  logic                rx_ready_i,
  output logic [DATA_W-1:0]   rx_data_o,
  output logic                rx_valid_o,
  output logic                rx_parity_err_o,
  output logic                rx_frame_err_o,
  output logic                rx_overrun_o,
  output logic                rx_busy_o
);

  localparam int unsigned      CNT_W    = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

  logic rx_s;
  logic rx_fall_c;

  uart_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rx_line   (uart_rx_i),
    .rx_s      (rx_s),
    .rx_fall_c (rx_fall_c)
  );

  uart_state_e          state_q,     state_nxt;
  logic [CNT_W-1:0]     cnt_q,       cnt_nxt;
  logic [BIT_IDX_W-1:0] bit_q,       bit_nxt;
  logic [DATA_W-1:0]    data_q,      data_nxt;
  uart_conf_t           conf_q,      conf_nxt;
  logic                 par_err_q,   par_err_nxt;
  logic                 frame_err_q, frame_err_nxt;
  logic                 stop_q,      stop_nxt;
  logic                 frame_done_c;
  logic                 accept_c;

  // Frame FSM state and datapath registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      data_q      <= '0;
      conf_q      <= '0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      stop_q      <= 1'b0;
      rx_busy_o   <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      bit_q       <= bit_nxt;
      data_q      <= data_nxt;
      conf_q      <= conf_nxt;
      par_err_q   <= par_err_nxt;
      frame_err_q <= frame_err_nxt;
      stop_q      <= stop_nxt;
      rx_busy_o   <= (state_nxt != ST_IDLE);
    end
  end

  // Next-state and datapath updates; everything advances only on baud_en_i.
  always_comb begin
    state_nxt     = state_q;
    cnt_nxt       = cnt_q;
    bit_nxt       = bit_q;
    data_nxt      = data_q;
    conf_nxt      = conf_q;
    par_err_nxt   = par_err_q;
    frame_err_nxt = frame_err_q;
    stop_nxt      = stop_q;
    frame_done_c  = 1'b0;

    if (baud_en_i) begin
      if (state_q != ST_IDLE && !rx_en_i) begin
        state_nxt = ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            // Level test also catches a start bit already low on Idle re-entry.
            if (rx_en_i && (rx_fall_c || !rx_s)) begin
              state_nxt = ST_START_CHK;
              cnt_nxt   = '0;
              conf_nxt  = uart_conf_t'(rx_conf_i);
            end
          end
          ST_START_CHK: begin
            if (cnt_q == CNT_MID) begin
              cnt_nxt = '0;
              if (!rx_s) begin
                state_nxt     = ST_DATA;
                bit_nxt       = '0;
                data_nxt      = '0;
                par_err_nxt   = 1'b0;
                frame_err_nxt = 1'b0;
                stop_nxt      = 1'b0;
              end else begin
                state_nxt = ST_IDLE;
              end
            end else begin
              cnt_nxt = cnt_q + CNT_W'(1);
            end
          end
          ST_DATA: begin
            if (cnt_q == CNT_LAST) begin
              cnt_nxt         = '0;
              data_nxt[bit_q] = rx_s;
              bit_nxt         = bit_q + BIT_IDX_W'(1);
              if (bit_q == last_data_idx(conf_q.dsize)) begin
                state_nxt = conf_q.parity_en ? ST_PARITY : ST_STOP;
              end
            end else begin
              cnt_nxt = cnt_q + CNT_W'(1);
            end
          end
          ST_PARITY: begin
            if (cnt_q == CNT_LAST) begin
              cnt_nxt     = '0;
              // Unreceived MSBs are zero, so the full-width XOR is the frame's data parity.
              par_err_nxt = (^data_q) ^ rx_s;
              state_nxt   = ST_STOP;
            end else begin
              cnt_nxt = cnt_q + CNT_W'(1);
            end
          end
          ST_STOP: begin
            if (cnt_q == CNT_LAST) begin
              cnt_nxt       = '0;
              frame_err_nxt = frame_err_q | ~rx_s;
              if (stop_q || !two_stop_bits(conf_q.stop)) begin
                state_nxt = ST_DONE;
              end else begin
                stop_nxt = 1'b1;
              end
            end else begin
              cnt_nxt = cnt_q + CNT_W'(1);
            end
          end
          ST_DONE: begin
            frame_done_c = 1'b1;
            state_nxt    = ST_IDLE;
          end
          default: state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  assign accept_c = rx_valid_o & rx_ready_i;

  // Output holding register and handshake; a full, unaccepted register drops the new frame.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_data_o       <= '0;
      rx_valid_o      <= 1'b0;
      rx_parity_err_o <= 1'b0;
      rx_frame_err_o  <= 1'b0;
      rx_overrun_o    <= 1'b0;
    end else begin
      if (frame_done_c && (!rx_valid_o || rx_ready_i)) begin
        rx_data_o       <= data_q;
        rx_parity_err_o <= par_err_q;
        rx_frame_err_o  <= frame_err_q;
        rx_valid_o      <= 1'b1;
      end else if (accept_c) begin
        rx_valid_o <= 1'b0;
      end

      if (accept_c) begin
        rx_overrun_o <= 1'b0;
      end else if (frame_done_c && rx_valid_o) begin
        rx_overrun_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_module.sv
// Scoreboard bench for uart_rx_module: stimulus pushes the expected frame,
// a negedge monitor pops and compares on every accepted output.
module tb_uart_rx_module;

  localparam int BIT_CLKS = 16;

  logic       clk_i      = 1'b0;
  logic       rst_i      = 1'b0;
  logic       baud_en_i  = 1'b1;
  logic       rx_en_i    = 1'b1;
  logic [4:0] rx_conf_i  = 5'b0;
  logic       uart_rx_i  = 1'b1;
  logic       rx_ready_i = 1'b1;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_parity_err_o;
  logic       rx_frame_err_o;
  logic       rx_overrun_o;
  logic       rx_busy_o;

  uart_rx_module dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .baud_en_i       (baud_en_i),
    .rx_en_i         (rx_en_i),
    .rx_conf_i       (rx_conf_i),
    .uart_rx_i       (uart_rx_i),
    .rx_ready_i      (rx_ready_i),
    .rx_data_o       (rx_data_o),
    .rx_valid_o      (rx_valid_o),
    .rx_parity_err_o (rx_parity_err_o),
    .rx_frame_err_o  (rx_frame_err_o),
    .rx_overrun_o    (rx_overrun_o),
    .rx_busy_o       (rx_busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0] d;
    logic       p;
    logic       f;
    logic       o;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output must match the oldest expected frame.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_i && rx_valid_o && rx_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got data 0x%0h with no frame expected", rx_data_o);
      end else begin
        e = exp_q.pop_front();
        check("rx_data", 32'(rx_data_o), 32'(e.d));
        check("rx_parity_err", 32'(rx_parity_err_o), 32'(e.p));
        check("rx_frame_err", 32'(rx_frame_err_o), 32'(e.f));
        check("rx_overrun", 32'(rx_overrun_o), 32'(e.o));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send_bit(input logic b);
    uart_rx_i = b;
    idle(BIT_CLKS);
  endtask

  // Start bit, nbits data LSB first, optional parity bit, nstop stop bits.
  task automatic send_frame(input logic [7:0] d, input int nbits, input bit par_en,
                            input logic par_bit, input int nstop, input bit stop0_low);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(d[i]);
    if (par_en) send_bit(par_bit);
    for (int s = 0; s < nstop; s++) send_bit((s == 0) ? ~stop0_low : 1'b1);
  endtask

  task automatic push(input logic [7:0] d, input logic p, input logic f, input logic o);
    exp_t e;
    e.d = d; e.p = p; e.f = f; e.o = o;
    exp_q.push_back(e);
  endtask

  task automatic check_idle_outputs(input string tag, input logic [7:0] d);
    check({tag, "_valid"}, 32'(rx_valid_o), 32'd0);
    check({tag, "_data"}, 32'(rx_data_o), 32'(d));
    check({tag, "_perr"}, 32'(rx_parity_err_o), 32'd0);
    check({tag, "_ferr"}, 32'(rx_frame_err_o), 32'd0);
    check({tag, "_ovr"}, 32'(rx_overrun_o), 32'd0);
    check({tag, "_busy"}, 32'(rx_busy_o), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    idle(3);
    check_idle_outputs("reset", 8'h00);
    rst_i = 1'b1;
    idle(4);

    // 8N1 0x55.
    rx_conf_i = 5'b11000;
    push(8'h55, 1'b0, 1'b0, 1'b0);
    send_frame(8'h55, 8, 1'b0, 1'b0, 1, 1'b0);
    idle(20);

    // 8E1 0xA3: correct parity bit 0, then wrong parity bit 1.
    rx_conf_i = 5'b11001;
    push(8'hA3, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA3, 8, 1'b1, 1'b0, 1, 1'b0);
    idle(20);
    push(8'hA3, 1'b1, 1'b0, 1'b0);
    send_frame(8'hA3, 8, 1'b1, 1'b1, 1, 1'b0);
    idle(20);

    // 5N2 back-to-back, then a low first stop bit.
    rx_conf_i = 5'b00010;
    push(8'h1F, 1'b0, 1'b0, 1'b0);
    push(8'h0A, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1F, 5, 1'b0, 1'b0, 2, 1'b0);
    send_frame(8'h0A, 5, 1'b0, 1'b0, 2, 1'b0);
    idle(20);
    push(8'h0A, 1'b0, 1'b1, 1'b0);
    send_frame(8'h0A, 5, 1'b0, 1'b0, 2, 1'b1);
    idle(20);

    // Glitch: 4 clocks low is rejected at the start-bit midpoint.
    rx_conf_i = 5'b11000;
    uart_rx_i = 1'b0;
    idle(4);
    uart_rx_i = 1'b1;
    check("glitch_busy_high", 32'(rx_busy_o), 32'd1);
    idle(20);
    check("glitch_busy_low", 32'(rx_busy_o), 32'd0);
    check("glitch_valid", 32'(rx_valid_o), 32'd0);

    // Overrun: second frame dropped while the first is unaccepted.
    rx_ready_i = 1'b0;
    push(8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(8'h11, 8, 1'b0, 1'b0, 1, 1'b0);
    idle(5);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1, 1'b0);
    idle(5);
    check("ovr_set", 32'(rx_overrun_o), 32'd1);
    check("ovr_valid_held", 32'(rx_valid_o), 32'd1);
    check("ovr_data_kept", 32'(rx_data_o), 32'h11);
    rx_ready_i = 1'b1;
    idle(1);
    rx_ready_i = 1'b0;
    idle(1);
    check("ovr_valid_cleared", 32'(rx_valid_o), 32'd0);
    check("ovr_cleared", 32'(rx_overrun_o), 32'd0);
    rx_ready_i = 1'b1;
    idle(10);

    // Abort via rx_en_i after 3 data bits of 0x5A.
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rx_en_i = 1'b0;
    idle(3);
    check("abort_busy", 32'(rx_busy_o), 32'd0);
    check("abort_valid", 32'(rx_valid_o), 32'd0);
    uart_rx_i = 1'b1;
    idle(20);
    rx_en_i = 1'b1;
    idle(5);
    check("abort_idle_busy", 32'(rx_busy_o), 32'd0);
    push(8'h3C, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b0);
    idle(20);

    // Reset asserted mid-frame.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rst_i = 1'b0;
    #2;
    check_idle_outputs("midrst", 8'h00);
    uart_rx_i = 1'b1;
    idle(5);
    rst_i = 1'b1;
    idle(20);
    push(8'hC3, 1'b0, 1'b0, 1'b0);
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1, 1'b0);
    idle(20);

    // Every expected frame must have been presented.
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk_i);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_module.md
Name: uart_rx_module

Overview:
UART receive engine, the receive-side counterpart of the team's tx_module. It oversamples the serial input uart_rx_i at 16x using the shared baud_en_i tick. It deserialises frames of 5-8 data bits, LSB first, with optional even parity and 1 or 2 stop bits. Received bytes go to the register/host side through a valid/ready handshake, with parity, framing and overrun status.

Parameters:
OVERSAMPLE, 16, baud_en_i ticks per bit; sample counter width is clog2(OVERSAMPLE).
SYNC_STAGES, 2, synchroniser flops on uart_rx_i.

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous, active-low reset
baud_en_i  in  1  oversample tick, OVERSAMPLE per bit period
rx_en_i  in  1  receiver enable; when low, the FSM returns to Idle and no new frame is accepted
rx_conf_i  in  5  {data_size[1:0], stop_size[1:0], parity_en}; bits = 5+data_size; stop bits = 1 if stop_size==0, else 2
uart_rx_i  in  1  serial line, idle high, asynchronous
rx_ready_i  in  1  consumer accepts rx_data_o this clk
rx_data_o  out  8  received data, right-aligned, unused MSBs 0
rx_valid_o  out  1  rx_data_o and error flags valid; held until accepted
rx_parity_err_o  out  1  parity mismatch for the presented frame
rx_frame_err_o  out  1  a stop bit sampled low for the presented frame
rx_overrun_o  out  1  sticky; a frame completed while rx_valid_o was still high
rx_busy_o  out  1  high from start-bit detection until frame end

Behaviour:
- Reset values: all outputs 0, FSM in Idle, synchroniser flops 1.
- uart_rx_i passes through SYNC_STAGES flops; all decisions use the synchronised value rx_s.
- FSM, advancing only on baud_en_i:
  - Idle: when rx_en_i=1 and rx_s=0, go to StartChk, clear the sample counter and latch rx_conf_i.
  - StartChk: at sample count OVERSAMPLE/2-1 (7), if rx_s=0 go to Data with the counter cleared; else return to Idle (glitch reject, no flags).
  - Data: sample rx_s when count = OVERSAMPLE-1 (15); this is mid-bit. Shift into bit index data_cnt. After bit (5+data_size-1), go to Parity if parity_en, else Stop.
  - Parity: sample at 15; parity_err = (XOR of data bits) XOR sampled bit, i.e. even parity.
  - Stop: sample at 15; any low stop bit sets frame_err. After the last stop bit, go to Done.
  - Done: lasts one tick period. Load the output register, set rx_valid_o, then go to Idle.
- rx_busy_o is high in every state except Idle.
- Stop detection is mid-bit, so Idle is re-entered half a bit early. A new start bit is therefore caught even in back-to-back frames.
- Output handshake (clk_i domain, independent of baud_en_i):
  - rx_valid_o falls the clk after rx_valid_o&rx_ready_i.
  - On Done while rx_valid_o=1 and no accept in the same clk: set rx_overrun_o and keep the old data (new frame dropped).
  - On Done coinciding with an accept: load the new frame, keep rx_valid_o=1, no overrun.
- rx_overrun_o clears only on the clk where an accept occurs.
- rx_en_i deasserted mid-frame: abort to Idle on the next baud_en_i; no valid, no flags. The output register is unaffected.
- rx_conf_i changes mid-frame are ignored until the next start bit.
- Reset asserted mid-frame: immediate return to reset values.

Decomposition:
- Shared package uart_pkg (also used by tx_module):
  - FSM state encodings
  - OVERSAMPLE default
  - conf field positions: CONF_PARITY_EN=0, CONF_STOP=2:1, CONF_DSIZE=4:3
  - data/stop size decode constants
- One sub-module: uart_rx_sync, the SYNC_STAGES synchroniser with reset value 1. It outputs rx_s and falling-edge detect.

Test Plan:
- 8N1 (conf=5'b11000), send 0x55 with a baud_en_i every clk -> one rx_valid_o, rx_data_o=0x55, all errors 0.
- 8E1 (conf=5'b11001), send 0xA3 with the correct parity bit 0 -> data 0xA3, parity_err=0. Repeat with parity bit 1 -> parity_err=1, data still 0xA3.
- 5N2 (conf=5'b00010), send 0x1F then 0x0A back-to-back -> 0x1F then 0x0A, both stops honoured, no frame_err. Stop bit driven low -> frame_err=1.
- Glitch: uart_rx_i low for 4 ticks, then high -> no rx_valid_o, rx_busy_o drops after tick 7, FSM back in Idle.
- Overrun: rx_ready_i=0, send 0x11 then 0x22 -> rx_data_o=0x11, rx_overrun_o=1. Pulse rx_ready_i -> valid and overrun both clear.
- Mid-frame abort: drop rx_en_i after 3 data bits, and separately assert rst_i mid-frame -> no valid, outputs at reset/idle values. The next full frame is received correctly.
